// File: rtl/i2c_target_pkg.sv
//------------------------------------------------------------------------------
// i2c_target_pkg
// Shared state encoding and R/W bit values for the I2C target.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package i2c_target_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ADDR      = 3'd1;
    localparam logic [2:0] ST_ADDR_ACK  = 3'd2;
    localparam logic [2:0] ST_WRITE     = 3'd3;
    localparam logic [2:0] ST_WRITE_ACK = 3'd4;
    localparam logic [2:0] ST_READ      = 3'd5;
    localparam logic [2:0] ST_READ_ACK  = 3'd6;
    localparam logic [2:0] ST_IGNORE    = 3'd7;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/i2c_sync_edge.sv
//------------------------------------------------------------------------------
// i2c_sync_edge
// Two-flop synchronizer plus history flop with rise/fall detection.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module i2c_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_hist;

    // Reset to 1 so an idle (pulled-up) bus produces no edge after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_hist <= 1'b1;
        end else begin
            r_meta <= i_pin;
            r_sync <= r_meta;
            r_hist <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_rise  = r_sync & ~r_hist;
    assign o_fall  = ~r_sync & r_hist;

endmodule

`default_nettype wire

// File: rtl/i2c_target.sv
//------------------------------------------------------------------------------
// i2c_target
// 7-bit address I2C target with byte-wide write/read handshakes; no clock stretching.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module i2c_target
    import i2c_target_pkg::*;
#(
    parameter logic [6:0] ADDR = 7'h48
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl,
    inout  wire        sda,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack_en,
    input  logic [7:0] tx_data,
    output logic       tx_latch,
    output logic       rw,
    output logic       addr_match,
    output logic       start_det,
    output logic       stop_det,
    output logic       busy
);

    logic       w_scl_lvl, w_scl_rise, w_scl_fall;
    logic       w_sda_lvl, w_sda_rise, w_sda_fall;
    logic       w_start, w_stop;
    logic [7:0] w_shift_in;
    logic       w_addr_hit;
    logic       w_tx_latch;
    logic [2:0] w_next_state;

    logic [2:0] r_state;
    logic       r_phase;
    logic [2:0] r_bitcnt;
    logic [7:0] r_shift;
    logic [7:0] r_rx_data;
    logic       r_rx_valid;
    logic       r_ack_en;
    logic       r_rw;
    logic       r_addr_match;
    logic       r_start_det;
    logic       r_stop_det;
    logic       r_busy;
    logic       r_sda_low;

    i2c_sync_edge u_scl_sync (
        .clk     (clk),
        .rst     (reset),
        .i_pin   (scl),
        .o_level (w_scl_lvl),
        .o_rise  (w_scl_rise),
        .o_fall  (w_scl_fall)
    );

    i2c_sync_edge u_sda_sync (
        .clk     (clk),
        .rst     (reset),
        .i_pin   (sda),
        .o_level (w_sda_lvl),
        .o_rise  (w_sda_rise),
        .o_fall  (w_sda_fall)
    );

    assign w_start    = w_sda_fall & w_scl_lvl;
    assign w_stop     = w_sda_rise & w_scl_lvl;
    assign w_shift_in = {r_shift[6:0], w_sda_lvl};
    assign w_addr_hit = (w_shift_in[7:1] == ADDR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // r_phase marks that the ACK clock's rising edge has been seen, so the
    // next falling edge closes the ACK slot.
    always_comb begin
        w_next_state = r_state;
        if (w_start) begin
            w_next_state = ST_ADDR;
        end else if (w_stop) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_ADDR: begin
                    if (w_scl_rise && r_bitcnt == 3'd7)
                        w_next_state = w_addr_hit ? ST_ADDR_ACK : ST_IGNORE;
                end
                ST_ADDR_ACK: begin
                    if (w_scl_fall && r_phase)
                        w_next_state = (r_rw == RW_READ) ? ST_READ : ST_WRITE;
                end
                ST_WRITE: begin
                    if (w_scl_rise && r_bitcnt == 3'd7)
                        w_next_state = ST_WRITE_ACK;
                end
                ST_WRITE_ACK: begin
                    if (w_scl_fall && r_phase)
                        w_next_state = ST_WRITE;
                end
                ST_READ: begin
                    if (w_scl_fall && r_bitcnt == 3'd7)
                        w_next_state = ST_READ_ACK;
                end
                ST_READ_ACK: begin
                    if (w_scl_rise && w_sda_lvl)
                        w_next_state = ST_IGNORE;
                    else if (w_scl_fall && r_phase)
                        w_next_state = ST_READ;
                end
                default: w_next_state = r_state;
            endcase
        end
    end

    always_comb begin
        w_tx_latch = 1'b0;
        if (w_scl_fall && r_phase) begin
            if (r_state == ST_ADDR_ACK && r_rw == RW_READ)
                w_tx_latch = 1'b1;
            if (r_state == ST_READ_ACK)
                w_tx_latch = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_phase      <= 1'b0;
            r_bitcnt     <= 3'd0;
            r_shift      <= 8'h00;
            r_rx_data    <= 8'h00;
            r_rx_valid   <= 1'b0;
            r_ack_en     <= 1'b0;
            r_rw         <= RW_WRITE;
            r_addr_match <= 1'b0;
            r_start_det  <= 1'b0;
            r_stop_det   <= 1'b0;
            r_busy       <= 1'b0;
            r_sda_low    <= 1'b0;
        end else begin
            r_rx_valid   <= 1'b0;
            r_addr_match <= 1'b0;
            r_start_det  <= w_start;
            r_stop_det   <= w_stop;
            if (r_rx_valid)
                r_ack_en <= rx_ack_en;

            if (w_start || w_stop) begin
                r_phase   <= 1'b0;
                r_bitcnt  <= 3'd0;
                r_shift   <= 8'h00;
                r_busy    <= 1'b0;
                r_sda_low <= 1'b0;
            end else begin
                case (r_state)
                    ST_ADDR: begin
                        if (w_scl_rise) begin
                            r_shift  <= w_shift_in;
                            r_bitcnt <= r_bitcnt + 3'd1;
                            if (r_bitcnt == 3'd7 && w_addr_hit) begin
                                r_addr_match <= 1'b1;
                                r_rw         <= w_sda_lvl;
                                r_busy       <= 1'b1;
                            end
                        end
                    end
                    ST_ADDR_ACK, ST_WRITE_ACK: begin
                        if (w_scl_rise) begin
                            r_phase <= 1'b1;
                        end else if (w_scl_fall) begin
                            if (!r_phase) begin
                                r_sda_low <= (r_state == ST_ADDR_ACK) ? 1'b1 : r_ack_en;
                            end else begin
                                r_phase  <= 1'b0;
                                r_bitcnt <= 3'd0;
                                if (w_tx_latch) begin
                                    r_shift   <= tx_data;
                                    r_sda_low <= ~tx_data[7];
                                end else begin
                                    r_sda_low <= 1'b0;
                                end
                            end
                        end
                    end
                    ST_WRITE: begin
                        if (w_scl_rise) begin
                            r_shift  <= w_shift_in;
                            r_bitcnt <= r_bitcnt + 3'd1;
                            if (r_bitcnt == 3'd7) begin
                                r_rx_data  <= w_shift_in;
                                r_rx_valid <= 1'b1;
                            end
                        end
                    end
                    ST_READ: begin
                        // Rotate so the next bit to send always sits in bit 7.
                        if (w_scl_fall) begin
                            if (r_bitcnt == 3'd7) begin
                                r_sda_low <= 1'b0;
                                r_bitcnt  <= 3'd0;
                            end else begin
                                r_shift   <= {r_shift[6:0], r_shift[7]};
                                r_sda_low <= ~r_shift[6];
                                r_bitcnt  <= r_bitcnt + 3'd1;
                            end
                        end
                    end
                    ST_READ_ACK: begin
                        if (w_scl_rise) begin
                            if (!w_sda_lvl)
                                r_phase <= 1'b1;
                        end else if (w_scl_fall && r_phase) begin
                            r_phase   <= 1'b0;
                            r_bitcnt  <= 3'd0;
                            r_shift   <= tx_data;
                            r_sda_low <= ~tx_data[7];
                        end
                    end
                    default: begin
                        r_phase   <= 1'b0;
                        r_sda_low <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sda        = r_sda_low ? 1'b0 : 1'bz;
    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign tx_latch   = w_tx_latch;
    assign rw         = r_rw;
    assign addr_match = r_addr_match;
    assign start_det  = r_start_det;
    assign stop_det   = r_stop_det;
    assign busy       = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_i2c_target.sv
//------------------------------------------------------------------------------
// tb_i2c_target
// Directed bus-level bench for i2c_target acting as a bit-banged initiator.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_i2c_target;
    import i2c_target_pkg::*;

    localparam int QCLK = 8;

    logic       clk;
    logic       reset;
    logic       scl;
    logic       r_m_sda;
    wire        sda;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack_en;
    logic [7:0] tx_data;
    logic       tx_latch;
    logic       rw;
    logic       addr_match;
    logic       start_det;
    logic       stop_det;
    logic       busy;

    pullup (sda);
    assign sda = r_m_sda ? 1'bz : 1'b0;

    i2c_target #(.ADDR(7'h48)) dut (
        .clk        (clk),
        .reset      (reset),
        .scl        (scl),
        .sda        (sda),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ack_en  (rx_ack_en),
        .tx_data    (tx_data),
        .tx_latch   (tx_latch),
        .rw         (rw),
        .addr_match (addr_match),
        .start_det  (start_det),
        .stop_det   (stop_det),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    int         n_rxv = 0, n_txl = 0, n_am = 0, n_start = 0, n_stop = 0;
    int         b_rxv, b_txl, b_am, b_start, b_stop;
    logic [7:0] r_rx_last = 8'h00;
    logic [7:0] r_rx_prev = 8'h00;
    logic       ack;
    logic       bit_v;
    logic [7:0] d1, d2;

    always @(posedge clk) begin
        if (rx_valid) begin
            n_rxv     <= n_rxv + 1;
            r_rx_prev <= r_rx_last;
            r_rx_last <= rx_data;
        end
        if (tx_latch)   n_txl   <= n_txl + 1;
        if (addr_match) n_am    <= n_am + 1;
        if (start_det)  n_start <= n_start + 1;
        if (stop_det)   n_stop  <= n_stop + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        b_rxv = n_rxv; b_txl = n_txl; b_am = n_am; b_start = n_start; b_stop = n_stop;
    endtask

    task automatic wait_q();
        repeat (QCLK) @(negedge clk);
    endtask

    task automatic bus_start();
        r_m_sda = 1'b1; wait_q();
        scl = 1'b1;     wait_q();
        r_m_sda = 1'b0; wait_q();
        scl = 1'b0;     wait_q();
    endtask

    task automatic bus_stop();
        r_m_sda = 1'b0; wait_q();
        scl = 1'b1;     wait_q();
        r_m_sda = 1'b1; wait_q();
        wait_q();
    endtask

    task automatic bit_out(input logic b);
        r_m_sda = b; wait_q();
        scl = 1'b1;  wait_q(); wait_q();
        scl = 1'b0;  wait_q();
    endtask

    task automatic bit_in(output logic b);
        r_m_sda = 1'b1; wait_q();
        scl = 1'b1;     wait_q();
        b = sda;        wait_q();
        scl = 1'b0;     wait_q();
    endtask

    task automatic byte_out(input logic [7:0] d, output logic a);
        for (int i = 7; i >= 0; i--) bit_out(d[i]);
        bit_in(a);
    endtask

    task automatic read8(output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            bit_in(b);
            d[i] = b;
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; scl = 1'b1; r_m_sda = 1'b1; rx_ack_en = 1'b1; tx_data = 8'h00;
        repeat (4) @(negedge clk);
        check_eq("rst_rx_data", rx_data, 8'h00);
        check_eq("rst_flags", {rw, busy}, 2'b00);
        check_eq("rst_pulses", {rx_valid, tx_latch, addr_match, start_det, stop_det}, 5'b0);
        check_eq("rst_sda", sda, 1'b1);
        reset = 1'b0;
        wait_q();

        // Write 0x90, 0xA5, 0x3C, STOP
        snap();
        bus_start();
        byte_out(8'h90, ack); check_eq("wr_addr_ack", ack, 1'b0);
        check_eq("wr_busy", busy, 1'b1);
        check_eq("wr_rw", rw, 1'b0);
        byte_out(8'hA5, ack); check_eq("wr_b1_ack", ack, 1'b0);
        byte_out(8'h3C, ack); check_eq("wr_b2_ack", ack, 1'b0);
        bus_stop();
        check_eq("wr_am_cnt", n_am - b_am, 1);
        check_eq("wr_rxv_cnt", n_rxv - b_rxv, 2);
        check_eq("wr_rx_first", r_rx_prev, 8'hA5);
        check_eq("wr_rx_second", r_rx_last, 8'h3C);
        check_eq("wr_stop_cnt", n_stop - b_stop, 1);
        check_eq("wr_busy_after", busy, 1'b0);

        // Read 0x91: 0x5A (ACK), 0xC3 (NACK)
        snap();
        tx_data = 8'h5A;
        bus_start();
        byte_out(8'h91, ack); check_eq("rd_addr_ack", ack, 1'b0);
        check_eq("rd_rw", rw, 1'b1);
        read8(d1);
        tx_data = 8'hC3;
        bit_out(1'b0);
        read8(d2);
        bit_out(1'b1);
        check_eq("rd_byte1", d1, 8'h5A);
        check_eq("rd_byte2", d2, 8'hC3);
        check_eq("rd_state_ignore", dut.r_state, ST_IGNORE);
        bus_stop();
        check_eq("rd_state_idle", dut.r_state, ST_IDLE);
        check_eq("rd_txl_cnt", n_txl - b_txl, 2);

        // Address mismatch 0x92, bus ignored until STOP
        snap();
        bus_start();
        byte_out(8'h92, ack); check_eq("mm_nack", ack, 1'b1);
        byte_out(8'h90, ack); check_eq("mm_ignored_nack", ack, 1'b1);
        check_eq("mm_busy", busy, 1'b0);
        check_eq("mm_state", dut.r_state, ST_IGNORE);
        bus_stop();
        check_eq("mm_am_cnt", n_am - b_am, 0);
        check_eq("mm_rxv_cnt", n_rxv - b_rxv, 0);
        check_eq("mm_state_idle", dut.r_state, ST_IDLE);

        // Write 0x90, repeated START, read 0x91
        snap();
        tx_data = 8'h77;
        bus_start();
        byte_out(8'h90, ack); check_eq("rs_w_ack", ack, 1'b0);
        check_eq("rs_rw0", rw, 1'b0);
        bus_start();
        byte_out(8'h91, ack); check_eq("rs_r_ack", ack, 1'b0);
        check_eq("rs_rw1", rw, 1'b1);
        read8(d1);
        bit_out(1'b1);
        bus_stop();
        check_eq("rs_byte", d1, 8'h77);
        check_eq("rs_start_cnt", n_start - b_start, 2);
        check_eq("rs_am_cnt", n_am - b_am, 2);
        check_eq("rs_txl_cnt", n_txl - b_txl, 1);

        // STOP after 4 data bits
        snap();
        bus_start();
        byte_out(8'h90, ack); check_eq("pt_addr_ack", ack, 1'b0);
        bit_out(1'b1); bit_out(1'b0); bit_out(1'b1); bit_out(1'b1);
        bus_stop();
        check_eq("pt_rxv_cnt", n_rxv - b_rxv, 0);
        check_eq("pt_state", dut.r_state, ST_IDLE);
        check_eq("pt_busy", busy, 1'b0);

        // Write with rx_ack_en=0: data byte NACKed
        snap();
        rx_ack_en = 1'b0;
        bus_start();
        byte_out(8'h90, ack); check_eq("nk_addr_ack", ack, 1'b0);
        byte_out(8'h11, ack); check_eq("nk_data_nack", ack, 1'b1);
        bus_stop();
        check_eq("nk_rxv_cnt", n_rxv - b_rxv, 1);
        check_eq("nk_rx_data", rx_data, 8'h11);
        rx_ack_en = 1'b1;

        // Reset while the address ACK is pulling SDA low
        bus_start();
        for (int i = 7; i >= 0; i--) bit_out(bit_v_of(8'h90, i));
        r_m_sda = 1'b1;
        wait_q();
        check_eq("rr_ack_low", sda, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("rr_sda_released", sda, 1'b1);
        check_eq("rr_rx_data", rx_data, 8'h00);
        check_eq("rr_flags", {rw, busy}, 2'b00);
        check_eq("rr_pulses", {rx_valid, tx_latch, addr_match, start_det, stop_det}, 5'b0);
        wait_q();
        reset = 1'b0;
        wait_q();
        bus_stop();
        check_eq("rr_state_idle", dut.r_state, ST_IDLE);
        snap();
        bus_start();
        byte_out(8'h90, ack); check_eq("rr_addr_ack", ack, 1'b0);
        byte_out(8'h5E, ack); check_eq("rr_data_ack", ack, 1'b0);
        bus_stop();
        check_eq("rr_rx_after", rx_data, 8'h5E);
        check_eq("rr_am_cnt", n_am - b_am, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    function automatic logic bit_v_of(input logic [7:0] d, input int i);
        return d[i];
    endfunction

endmodule

`default_nettype wire
